// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter; master drives the controls, slave is the counter.
interface updown_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             sat_mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output clr, load, load_val, en, up, sat_mode,
        input  count, tc, ovf
    );

    modport slave (
        input  clr, load, load_val, en, up, sat_mode,
        output count, tc, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clear, clamped load, wrap/saturate mode, tc strobe and ovf flag.
// Define UPDOWN_COUNTER_OVF_STICKY_EN to make ovf sticky until clr/reset (default: 1-cycle pulse).
module updown_mod_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    updown_mod_counter_if.slave  bus
);

    logic [WIDTH-1:0] count_q, count_nxt;
    logic             ovf_q, ovf_nxt;
    logic             at_bound;
    logic             boundary;

    // Bound depends on direction; with MAX_VAL=0 both bounds hold, so every enabled cycle hits one.
    assign at_bound = bus.up ? (count_q == MAX_VAL) : (count_q == '0);
    assign boundary = bus.en & ~bus.clr & ~bus.load & at_bound;

    always_comb begin
        count_nxt = count_q;
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        ovf_nxt   = ovf_q;
`else
        ovf_nxt   = 1'b0;
`endif
        if (bus.clr) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (bus.load) begin
            count_nxt = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en) begin
            if (boundary) begin
                ovf_nxt = 1'b1;
                if (!bus.sat_mode)
                    count_nxt = bus.up ? '0 : MAX_VAL;
            end else begin
                count_nxt = bus.up ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.tc    = boundary;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized + directed bench for updown_mod_counter against an arithmetic reference model.
module tb_updown_mod_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(4)) b4();
    updown_mod_counter_if #(.WIDTH(8)) b8();

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    updown_mod_counter #(.WIDTH(8))                 dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    typedef struct { int c; int o; } mst_t;
    mst_t m4, m8;

    function automatic mst_t mnext(mst_t s, int m, bit clr, bit load, int lv, bit en, bit up, bit sat);
        mst_t n;
        n = s;
`ifndef UPDOWN_COUNTER_OVF_STICKY_EN
        n.o = 0;
`endif
        if (clr) begin
            n.c = 0;
            n.o = 0;
        end else if (load) begin
            n.c = (lv > m) ? m : lv;
        end else if (en) begin
            if (up ? (s.c == m) : (s.c == 0)) n.o = 1;
            if (up) n.c = sat ? ((s.c + 1 > m) ? m : s.c + 1) : (s.c + 1) % (m + 1);
            else    n.c = sat ? ((s.c > 0) ? s.c - 1 : 0)     : (s.c + m) % (m + 1);
        end
        return n;
    endfunction

    function automatic bit mtc(int c, int m, bit clr, bit load, bit en, bit up);
        return en && !clr && !load && (up ? (c == m) : (c == 0));
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 <= '{0, 0};
            m8 <= '{0, 0};
        end else begin
            m4 <= mnext(m4, 9,   b4.clr, b4.load, int'(b4.load_val), b4.en, b4.up, b4.sat_mode);
            m8 <= mnext(m8, 255, b8.clr, b8.load, int'(b8.load_val), b8.en, b8.up, b8.sat_mode);
        end
    end

    // Every-cycle compare, mid-cycle so registered outputs and tc have settled.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("count4", int'(b4.count), m4.c);
            chk("ovf4",   int'(b4.ovf),   m4.o);
            chk("tc4",    int'(b4.tc),    int'(mtc(m4.c, 9, b4.clr, b4.load, b4.en, b4.up)));
            chk("count8", int'(b8.count), m8.c);
            chk("ovf8",   int'(b8.ovf),   m8.o);
            chk("tc8",    int'(b8.tc),    int'(mtc(m8.c, 255, b8.clr, b8.load, b8.en, b8.up)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        b4.clr = 0; b4.load = 0; b4.load_val = '0; b4.en = 0; b4.up = 1; b4.sat_mode = 0;
    endtask

    int sticky;

    initial begin
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        sticky = 1;
`else
        sticky = 0;
`endif
        idle4();
        b8.clr = 0; b8.load = 0; b8.load_val = '0; b8.en = 0; b8.up = 1; b8.sat_mode = 0;

        // reset held while enabled
        b4.en = 1;
        repeat (3) cyc();
        chk("rst_count", int'(b4.count), 0);
        chk("rst_ovf",   int'(b4.ovf),   0);
        rst_n = 1;
        cmp_en = 1;

        // count up with wrap
        b4.en = 1; b4.up = 1; b4.sat_mode = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) chk("tc_at9", int'(b4.tc), 1);
            cyc();
            chk("up_wrap_count", int'(b4.count), i % 10);
        end
        chk("wrap_ovf", int'(b4.ovf), 1);
        b4.en = 0;
        cyc();
        chk("ovf_after_idle", int'(b4.ovf), sticky);

        // load then saturating down count
        idle4(); b4.load = 1; b4.load_val = 4'd3;
        cyc();
        b4.load = 0; b4.up = 0; b4.sat_mode = 1; b4.en = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("sat_down", int'(b4.count), (i < 3) ? 2 - i : 0);
            if (i >= 2) chk("tc_at0", int'(b4.tc), 1);
        end

        // priority and clamp
        idle4(); b4.load = 1; b4.load_val = 4'd15;
        cyc();
        chk("load_clamp", int'(b4.count), 9);
        b4.clr = 1; b4.en = 1;
        cyc();
        chk("clr_wins", int'(b4.count), 0);
        b4.clr = 0; b4.load_val = 4'd4;
        cyc();
        chk("load_beats_en", int'(b4.count), 4);

        // down-wrap from 0, then ovf behaviour over idle counting and a load
        idle4(); b4.clr = 1;
        cyc();
        b4.clr = 0; b4.up = 0; b4.en = 1;
        cyc();
        chk("down_wrap", int'(b4.count), 9);
        chk("down_ovf",  int'(b4.ovf),   1);
        repeat (5) cyc();
        chk("cnt_after5", int'(b4.count), 4);
        chk("ovf_after5", int'(b4.ovf),   sticky);
        b4.en = 0; b4.load = 1; b4.load_val = 4'd2;
        cyc();
        chk("ovf_after_load", int'(b4.ovf), sticky);
        b4.load = 0; b4.clr = 1;
        cyc();
        chk("ovf_after_clr", int'(b4.ovf), 0);

        // async reset mid-count at 5
        idle4(); b4.en = 1;
        repeat (5) cyc();
        chk("mid_count", int'(b4.count), 5);
        #2 rst_n = 0;
        #1 chk("async_rst", int'(b4.count), 0);
        @(posedge clk); #1 rst_n = 1;
        idle4();

        // 8-bit full-range wrap and direction reversal
        b8.load = 1; b8.load_val = 8'd250;
        cyc();
        b8.load = 0; b8.en = 1; b8.up = 1; b8.sat_mode = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk("w8_up", int'(b8.count), (250 + i) % 256);
        end
        chk("w8_ovf", int'(b8.ovf), 1);
        b8.up = 0;
        cyc();
        chk("w8_rev", int'(b8.count), 255);
        b8.up = 1;
        cyc();
        chk("w8_fwd", int'(b8.count), 0);

        // random phase, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            b4.clr      = ($urandom_range(15) == 0);
            b4.load     = ($urandom_range(7) == 0);
            b4.load_val = 4'($urandom);
            b4.en       = ($urandom_range(3) != 0);
            b4.up       = ($urandom_range(1) == 1);
            b4.sat_mode = ($urandom_range(2) == 0);
            b8.clr      = ($urandom_range(31) == 0);
            b8.load     = ($urandom_range(15) == 0);
            b8.load_val = 8'($urandom);
            b8.en       = ($urandom_range(3) != 0);
            b8.up       = ($urandom_range(4) != 0);
            b8.sat_mode = ($urandom_range(3) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
